// File: rtl/f5_frame_sequencer_pkg.sv
// Shared types and constants for the F_5 frame sequencer, its stage wrapper
// and the bench.
package f5_frame_sequencer_pkg;

    localparam int DATA_W     = 12;
    localparam int F5_LATENCY = 2;

    typedef enum logic [1:0] {
        FILL,
        HOLD,
        LAUNCH,
        FLIGHT
    } seq_state_t;

endpackage

// File: rtl/f5_frame_sequencer_if.sv
// Serial sample-in / result-out stream pair of the frame sequencer.
interface f5_frame_sequencer_if #(
    parameter int W = 12
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/f5_butterfly_stage.sv
// Registered 4-point butterfly (F_5): register in, halve the sums, register out.
// Two clock edges from input sample to valid output.
module f5_butterfly_stage
    import f5_frame_sequencer_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_i0,
    input  logic [W-1:0] i_i1,
    input  logic [W-1:0] i_i2,
    input  logic [W-1:0] i_i3,
    output logic [W-1:0] o_o0,
    output logic [W-1:0] o_o1,
    output logic [W-1:0] o_o2,
    output logic [W-1:0] o_o3
);
    logic [W-1:0] r_i0, r_i1, r_i2, r_i3;
    logic signed [W+1:0] w_a, w_b, w_c, w_d;
    logic signed [W+1:0] w_s0, w_s1, w_s2, w_s3;

    // Two guard bits keep the four-term sums exact before the halving shift.
    assign w_a  = {{2{r_i0[W-1]}}, r_i0};
    assign w_b  = {{2{r_i1[W-1]}}, r_i1};
    assign w_c  = {{2{r_i2[W-1]}}, r_i2};
    assign w_d  = {{2{r_i3[W-1]}}, r_i3};
    assign w_s0 = w_a + w_b + w_c + w_d;
    assign w_s1 = w_a - w_c;
    assign w_s2 = w_a - w_b + w_c - w_d;
    assign w_s3 = w_b - w_d;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_i0 <= '0;
            r_i1 <= '0;
            r_i2 <= '0;
            r_i3 <= '0;
            o_o0 <= '0;
            o_o1 <= '0;
            o_o2 <= '0;
            o_o3 <= '0;
        end else begin
            r_i0 <= i_i0;
            r_i1 <= i_i1;
            r_i2 <= i_i2;
            r_i3 <= i_i3;
            o_o0 <= W'(w_s0 >>> 1);
            o_o1 <= W'(w_s1 >>> 1);
            o_o2 <= W'(w_s2 >>> 1);
            o_o3 <= W'(w_s3 >>> 1);
        end
    end
endmodule

// File: rtl/f5_result_drain.sv
// Four-word result buffer replayed serially with valid/ready, plus the
// completed-frame counter.
module f5_result_drain
    import f5_frame_sequencer_pkg::*;
#(
    parameter int W     = DATA_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_capture,
    input  logic [W-1:0]     i_word0,
    input  logic [W-1:0]     i_word1,
    input  logic [W-1:0]     i_word2,
    input  logic [W-1:0]     i_word3,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [W-1:0]     o_data,
    output logic             o_last,
    output logic             o_full,
    output logic             o_done,
    output logic [CNT_W-1:0] o_frame_cnt
);
    logic [W-1:0] r_buf [4];
    logic [1:0]   r_rd_cnt;
    logic         r_full;
    logic         w_xfer;

    assign w_xfer      = r_full && i_ready;
    assign o_done      = w_xfer && (r_rd_cnt == 2'd3);
    assign o_valid     = r_full;
    assign o_data      = r_full ? r_buf[r_rd_cnt] : '0;
    assign o_last      = r_full && (r_rd_cnt == 2'd3);
    assign o_full      = r_full;

    // A capture only ever lands on an empty buffer, so it never races a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_buf[i] <= '0;
            r_rd_cnt    <= 2'd0;
            r_full      <= 1'b0;
            o_frame_cnt <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < 4; i++) r_buf[i] <= '0;
            r_rd_cnt    <= 2'd0;
            r_full      <= 1'b0;
            o_frame_cnt <= '0;
        end else if (i_capture) begin
            r_buf[0] <= i_word0;
            r_buf[1] <= i_word1;
            r_buf[2] <= i_word2;
            r_buf[3] <= i_word3;
            r_rd_cnt <= 2'd0;
            r_full   <= 1'b1;
        end else if (w_xfer) begin
            r_rd_cnt <= r_rd_cnt + 2'd1;
            if (r_rd_cnt == 2'd3) begin
                r_full      <= 1'b0;
                o_frame_cnt <= o_frame_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/f5_frame_sequencer.sv
// Gathers four serial samples into a frame, launches it into the external
// F_5 stage, waits out its latency and hands the results to the drain.
module f5_frame_sequencer
    import f5_frame_sequencer_pkg::*;
#(
    parameter int W       = DATA_W,
    parameter int LATENCY = F5_LATENCY,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_sclr,
    f5_frame_sequencer_if.slave bus,
    output logic [W-1:0]        o_dp_i0,
    output logic [W-1:0]        o_dp_i1,
    output logic [W-1:0]        o_dp_i2,
    output logic [W-1:0]        o_dp_i3,
    output logic                o_dp_reset,
    input  logic [W-1:0]        i_dp_o0,
    input  logic [W-1:0]        i_dp_o1,
    input  logic [W-1:0]        i_dp_o2,
    input  logic [W-1:0]        i_dp_o3,
    output logic                o_busy,
    output logic [CNT_W-1:0]    o_frame_cnt
);
    localparam int LAT_W = $clog2(LATENCY + 1);

    seq_state_t       r_state;
    logic [1:0]       r_fill_cnt;
    logic [LAT_W-1:0] r_lat_cnt;
    logic [W-1:0]     r_slot [4];
    logic             r_in_ready;
    logic             r_dp_reset;

    logic w_in_xfer;
    logic w_capture;
    logic w_buf_full;
    logic w_drain_done;
    logic w_buf_free;

    assign w_in_xfer  = bus.in_valid && r_in_ready && (r_state == FILL);
    assign w_capture  = (r_state == FLIGHT) && (r_lat_cnt == LAT_W'(1));
    assign w_buf_free = !w_buf_full || w_drain_done;

    assign bus.in_ready = r_in_ready;
    assign o_dp_i0      = r_slot[0];
    assign o_dp_i1      = r_slot[1];
    assign o_dp_i2      = r_slot[2];
    assign o_dp_i3      = r_slot[3];
    assign o_dp_reset   = r_dp_reset;
    assign o_busy       = (r_state != FILL) || w_buf_full || (r_fill_cnt != 2'd0);

    // Slots are written only while filling, so DP_I stays put from launch to capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_fill_cnt <= 2'd0;
            r_lat_cnt  <= '0;
            r_in_ready <= 1'b0;
            r_dp_reset <= 1'b1;
            for (int i = 0; i < 4; i++) r_slot[i] <= '0;
        end else if (i_sclr) begin
            r_state    <= FILL;
            r_fill_cnt <= 2'd0;
            r_lat_cnt  <= '0;
            r_in_ready <= 1'b0;
            r_dp_reset <= 1'b1;
            for (int i = 0; i < 4; i++) r_slot[i] <= '0;
        end else begin
            r_dp_reset <= 1'b0;
            case (r_state)
                FILL: begin
                    r_in_ready <= 1'b1;
                    if (w_in_xfer) begin
                        r_slot[r_fill_cnt] <= bus.in_data;
                        r_fill_cnt         <= r_fill_cnt + 2'd1;
                        if (r_fill_cnt == 2'd3) begin
                            r_in_ready <= 1'b0;
                            r_state    <= w_buf_free ? LAUNCH : HOLD;
                        end
                    end
                end
                HOLD: begin
                    r_in_ready <= 1'b0;
                    if (w_buf_free) r_state <= LAUNCH;
                end
                LAUNCH: begin
                    r_in_ready <= 1'b0;
                    r_lat_cnt  <= LAT_W'(LATENCY);
                    r_state    <= FLIGHT;
                end
                FLIGHT: begin
                    r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    if (r_lat_cnt == LAT_W'(1)) begin
                        r_state    <= FILL;
                        r_fill_cnt <= 2'd0;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_in_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= FILL;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    f5_result_drain #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_drain (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (i_sclr),
        .i_capture   (w_capture),
        .i_word0     (i_dp_o0),
        .i_word1     (i_dp_o1),
        .i_word2     (i_dp_o2),
        .i_word3     (i_dp_o3),
        .i_ready     (bus.out_ready),
        .o_valid     (bus.out_valid),
        .o_data      (bus.out_data),
        .o_last      (bus.out_last),
        .o_full      (w_buf_full),
        .o_done      (w_drain_done),
        .o_frame_cnt (o_frame_cnt)
    );
endmodule
